// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// Define MMIO_UART_PARITY_EN to append an even-parity bit to every frame.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
`ifdef MMIO_UART_PARITY_EN
    localparam logic PARITY_FEAT = 1'b1;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    localparam logic PARITY_FEAT = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef MMIO_UART_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [BW-1:0]   baud_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r, shift_nxt_s;
    logic            tx_r, tx_nxt_s;
`ifdef MMIO_UART_PARITY_EN
    logic            parity_r;
`endif
    logic [7:0]      mem_r [0:3];
    logic [1:0]      wptr_r, rptr_r;
    logic [2:0]      count_r;
    logic            ovf_r;
    logic            empty_s, full_s, busy_s, bit_done_s;
    logic            pop_s, push_s, wr_data_s, wr_stat_s;
    logic [7:0]      head_s;
    logic [31:0]     status_s;
    logic            unused_s;

    assign hit        = (ALUResult[31:3] == BASE_ADDR[31:3]);
    assign wr_data_s  = MemWrite && hit && !ALUResult[2];
    assign wr_stat_s  = MemWrite && hit && ALUResult[2];
    assign empty_s    = (count_r == 3'd0);
    assign full_s     = (count_r == 3'd4);
    assign head_s     = mem_r[rptr_r];
    assign bit_done_s = (baud_r == BAUD_LAST);
    // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign push_s     = wr_data_s && (!full_s || pop_s);
    assign status_s   = {27'd0, PARITY_FEAT, ovf_r, empty_s, full_s, busy_s};
    assign tx         = tx_r;
    assign unused_s   = ^{ALUResult[1:0], WriteData[31:8]};

    // Register read mux; TXDATA and unmapped addresses read as zero.
    always_comb begin
        if (hit && ALUResult[2]) begin
            rdata = status_s;
        end else begin
            rdata = 32'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and FIFO pop decision.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = ST_START;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) begin
`ifdef MMIO_UART_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s && !empty_s) begin
                    state_nxt_s = ST_START;
                    pop_s       = 1'b1;
                end else if (bit_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pop_s       = 1'b0;
            end
        endcase
    end

    // Next shift-register contents: load on pop, shift at each data-bit boundary.
    always_comb begin
        if (pop_s) begin
            shift_nxt_s = head_s;
        end else if ((state_r == ST_DATA) && bit_done_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // FSM outputs: line level for the upcoming cycle and busy flag.
    always_comb begin
        busy_s = (state_r != ST_IDLE);
        case (state_nxt_s)
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef MMIO_UART_PARITY_EN
            ST_PARITY: tx_nxt_s = parity_r;
`endif
            default:   tx_nxt_s = 1'b1;
        endcase
    end

    // Serialiser datapath: baud counter, bit index, shift register, registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_r    <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            if ((state_r == ST_IDLE) || bit_done_s) begin
                baud_r <= {BW{1'b0}};
            end else begin
                baud_r <= baud_r + BAUD_ONE;
            end
            if (state_r != ST_DATA) begin
                bit_idx_r <= 3'd0;
            end else if (bit_done_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            shift_r <= shift_nxt_s;
            tx_r    <= tx_nxt_s;
`ifdef MMIO_UART_PARITY_EN
            if (pop_s) begin
                parity_r <= even_parity(head_s);
            end else begin
                parity_r <= parity_r;
            end
`endif
        end
    end

    // Byte FIFO and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r  <= 2'd0;
            rptr_r  <= 2'd0;
            count_r <= 3'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= WriteData[7:0];
                wptr_r        <= wptr_r + 2'd1;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 2'd1;
            end else begin
                rptr_r <= rptr_r;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + 3'd1;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - 3'd1;
            end else begin
                count_r <= count_r;
            end
            if (wr_stat_s && WriteData[3]) begin
                ovf_r <= 1'b0;
            end else if (wr_data_s && !push_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed bus stores, a serial decoder
// that pops expected bytes from a scoreboard, and STATUS/timing checks.
module tb_mmio_uart_tx;
    localparam int C = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PF    = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PF    = 32'h0;
`endif
    localparam int          FRAME = NBITS * C;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk, rst, MemWrite, hit, tx;
    logic [31:0] ALUResult, WriteData, rdata;
    int          cyc;
    int          checks, passes, fails;
    logic [7:0]  sb[$];
    int          starts[$];

    mmio_uart_tx #(.CLKS_PER_BIT(C), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .hit(hit), .rdata(rdata), .tx(tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        MemWrite = 1'b1; ALUResult = addr; WriteData = data;
        @(negedge clk);
        MemWrite = 1'b0; ALUResult = 32'd0; WriteData = 32'd0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        MemWrite = 1'b0; ALUResult = BASE + 32'd4; WriteData = 32'd0;
        #1;
        check({tag, " hit"}, {31'd0, hit}, 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic next_start(output int v);
        if (starts.size() != 0) v = starts.pop_front();
        else v = -1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check(tag, sb.size(), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Serial decoder: samples each bit near its centre and scores the frame.
    initial begin
        logic [10:0] bits;
        logic        sbit, ab;
        logic [7:0]  exp;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                for (int i = 0; i < 2; i++) begin @(negedge clk); ab |= rst; end
                sbit = tx;
                for (int j = 0; j < NBITS - 1; j++) begin
                    for (int i = 0; i < C; i++) begin @(negedge clk); ab |= rst; end
                    bits[j] = tx;
                end
                if (!ab) begin
                    check("unexpected frame", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("start bit", {31'd0, sbit}, 32'd0);
                        check("data byte", {24'd0, bits[7:0]}, {24'd0, exp});
`ifdef MMIO_UART_PARITY_EN
                        check("parity bit", {31'd0, bits[8]}, {31'd0, ^exp});
`endif
                        check("stop bit", {31'd0, bits[NBITS-2]}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int sc, st, bad;
        rst = 1'b1; MemWrite = 1'b0; ALUResult = 32'd0; WriteData = 32'd0;

        // Reset and idle.
        @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk_status("reset status", PF | 32'h4);
        ALUResult = 32'h0000_0010; #1;
        check("miss hit", {31'd0, hit}, 32'd0);
        check("miss rdata", rdata, 32'd0);
        ALUResult = BASE; #1;
        check("txdata hit", {31'd0, hit}, 32'd1);
        check("txdata rdata", rdata, 32'd0);

        // Single byte.
        sb.push_back(8'h55);
        store(BASE, 32'h0000_0055);
        sc = cyc;
        chk_status("push latency", PF);
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            ALUResult = BASE + 32'd4; #1;
            if (rdata[0] !== 1'b1) bad++;
        end
        check("single busy", bad, 32'd0);
        @(negedge clk);
        chk_status("single idle", PF | 32'h4);
        next_start(st);
        check("single start", st, sc + 1);
        check("single sb", sb.size(), 32'd0);

        // Stores outside the window must not push.
        store(32'h0000_0010, 32'h0000_0077);
        store(BASE + 32'd8, 32'h0000_0077);
        chk_status("miss store", PF | 32'h4);
        repeat (3) @(negedge clk);
        check("miss no frame", starts.size(), 32'd0);

        // Back-to-back frames.
        sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
        store(BASE, 32'h01);
        sc = cyc;
        store(BASE, 32'h02);
        store(BASE, 32'h03);
        drain("b2b drain", 4 * FRAME);
        next_start(st); check("b2b start0", st, sc + 1);
        next_start(st); check("b2b start1", st, sc + 1 + FRAME);
        next_start(st); check("b2b start2", st, sc + 1 + 2 * FRAME);
        chk_status("b2b idle", PF | 32'h4);

        // Overflow.
        sb.push_back(8'h11);
        for (int i = 0; i < 4; i++) sb.push_back(8'hA1 + 8'(i));
        store(BASE, 32'h11);
        for (int i = 0; i < 5; i++) store(BASE, 32'hA1 + i);
        chk_status("ovf status", PF | 32'hB);
        store(BASE + 32'd4, 32'hFFFF_FFF7);
        chk_status("ovf kept", PF | 32'hB);
        store(BASE + 32'd4, 32'h0000_0008);
        chk_status("ovf clear", PF | 32'h3);
        drain("ovf drain", 7 * FRAME);
        chk_status("ovf idle", PF | 32'h4);
        starts.delete();

        // Full FIFO with a push on the STOP->START pop edge.
        sb.push_back(8'h21);
        for (int i = 0; i < 4; i++) sb.push_back(8'h22 + 8'(i));
        sb.push_back(8'hAA);
        store(BASE, 32'h21);
        sc = cyc;
        for (int i = 0; i < 4; i++) store(BASE, 32'h22 + i);
        for (int i = 0; i < 2 * FRAME && cyc != sc + FRAME; i++) @(negedge clk);
        chk_status("full pre", PF | 32'h3);
        store(BASE, 32'h0000_00AA);
        chk_status("full+pop", PF | 32'h3);
        drain("full drain", 8 * FRAME);
        chk_status("full idle", PF | 32'h4);
        starts.delete();

        // Reset during data bit 3.
        store(BASE, 32'h0000_00C3);
        sc = cyc + 1;
        store(BASE, 32'h0000_005A);
        for (int i = 0; i < 2 * FRAME && cyc != sc + 4 * C + 1; i++) @(negedge clk);
        check("bit3 tx", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk_status("rst status", PF | 32'h4);
        starts.delete();
        repeat (3 * FRAME) @(negedge clk);
        check("no residual frame", starts.size(), 32'd0);
        check("rst line idle", {31'd0, tx}, 32'd1);
        check("rst sb", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
